alu_sub_seq: RTL and testbench
==============================

// Module: alu_sub_seq
// PURPOSE
// - Multi-cycle W-bit subtractor, the counterpart of the combinational 16-bit adder ALU: z = x - y.
// - Produces the same flag set as the adder: sign, zero, parity, carry (as borrow), overflow.
// - Operands are processed DIGIT bits per cycle, LSB first, so area can be traded for latency.
// - Sits beside the adder in the datapath; valid/ready on both input and output sides.
// PARAMETERS
// - W      16  operand/result width; must be a multiple of DIGIT
// - DIGIT  4   bits processed per BUSY cycle; legal values 1,2,4,8,16 (W%DIGIT==0)
// PORTS
// - clk        in   1  rising-edge clock
// - rst_n      in   1  asynchronous active-low reset
// - in_valid   in   1  operands x,y valid
// - in_ready   out  1  block can accept operands (high only in IDLE)
// - x          in   W  minuend
// - y          in   W  subtrahend
// - out_valid  out  1  z and flags valid (high only in DONE)
// - out_ready  in   1  consumer accepts result
// - z          out  W  difference, mod 2^W
// - sign       out  1  z[W-1]
// - zero       out  1  1 when z == 0
// - parity     out  1  ~^z (1 when z has an even number of ones)
// - carry      out  1  borrow: 1 when x < y unsigned
// - overflow   out  1  signed overflow: (x[W-1]&~y[W-1]&~z[W-1])|(~x[W-1]&y[W-1]&z[W-1])
// BEHAVIOUR
// - Reset (rst_n=0, any time, asynchronous): state=IDLE; in_ready=1; out_valid=0; z=0; sign=0;
//   zero=0; parity=0; carry=0; overflow=0; internal digit counter=0; borrow register=0.
// - FSM IDLE -> BUSY on in_valid&in_ready (x,y captured at that edge, borrow_in=0, counter=0).
// - BUSY: each edge subtracts one DIGIT slice (x_slice - y_slice - borrow), writes the slice into z
//   at position counter*DIGIT, updates borrow; running zero/parity accumulated per slice.
// - BUSY -> DONE at the edge processing slice N-1, N=W/DIGIT; flags final at that same edge.
// - Latency: out_valid rises N cycles after the accept edge (N=4 for defaults).
// - DONE: out_valid=1, z and flags stable; DONE -> IDLE on out_ready. out_ready ignored elsewhere.
// - in_ready=0 in BUSY and DONE; in_valid ignored there. No simultaneous accept-and-deliver.
// - z and flags hold their last values in IDLE and BUSY; only out_valid qualifies them.
// - carry = final borrow out of MSB slice; overflow computed from captured x,y MSBs and raw z MSB.
// - Boundaries: x==y -> z=0, zero=1, carry=0; 0-1 wraps to all-ones with carry=1;
//   DIGIT==W -> single BUSY cycle (N=1); reset mid-BUSY discards operation, no out_valid pulse.
// CONFIGURATION
// - Macro ALU_SUB_SAT_EN:
//   defined   -> on signed overflow z saturates: x neg, y pos -> z={1'b1,{W-1{1'b0}}};
//                x pos, y neg -> z={1'b0,{W-1{1'b1}}}. sign/zero/parity reflect saturated z;
//                carry and overflow still report the raw (unsaturated) subtraction. Saturation
//                applied at the BUSY->DONE edge; latency unchanged.
//   undefined -> z is the wrapping mod-2^W difference; no saturation logic built.
// TESTING
// - 0x0005-0x0003 -> z=0x0002, sign=0, zero=0, parity=0, carry=0, overflow=0; out_valid 4 cycles after accept.
// - 0x0000-0x0001 -> z=0xFFFF, sign=1, zero=0, parity=1, carry=1, overflow=0.
// - 0x8000-0x0001 -> z=0x7FFF, overflow=1, carry=0, sign=0, parity=0;
//   with ALU_SUB_SAT_EN: z=0x8000, sign=1, parity=0, overflow=1, carry=0.
// - 0x1234-0x1234 -> z=0x0000, zero=1, parity=1, carry=0; repeat with DIGIT=1 (16-cycle latency) and DIGIT=16 (1 cycle).
// - Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, z, flags stable, in_ready=0; new in_valid ignored.
// - Assert rst_n=0 during 2nd BUSY cycle -> all outputs at reset values immediately; next accepted op correct.

Source files
------------

// File: rtl/alu_sub_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sub_seq_if
// Purpose  : Operand/result bus for the digit-serial subtractor. Carries the
//            input valid/ready handshake with operands x,y and the output
//            valid/ready handshake with the difference z and its flags.
// Ports    : (interface signals)
//   in_valid  m->s  1  operands valid
//   in_ready  s->m  1  subtractor can accept operands
//   x, y      m->s  W  minuend, subtrahend
//   out_valid s->m  1  z and flags valid
//   out_ready m->s  1  consumer accepts result
//   z         s->m  W  difference mod 2^W
//   sign, zero, parity, carry, overflow  s->m  1  result flags
// Modports : master (operand producer / result consumer), slave (subtractor)
// Revision : 1.0  initial release
// ============================================================================
interface alu_sub_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         sign;
  logic         zero;
  logic         parity;
  logic         carry;
  logic         overflow;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, z, sign, zero, parity, carry, overflow
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, z, sign, zero, parity, carry, overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_sub_seq
// Purpose  : Multi-cycle W-bit subtractor z = x - y, processing DIGIT bits
//            per cycle LSB first. Produces sign, zero, parity (even = 1),
//            carry (borrow, x < y unsigned) and signed overflow.
// Ports    :
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   bus    slave    alu_sub_seq_if (operand/result handshakes, z, flags);
//                   the interface W must equal this module's W
// Params   : W (operand width, multiple of DIGIT), DIGIT (1,2,4,8,16)
// Config   : ALU_SUB_SAT_EN defined -> z saturates on signed overflow
//            (sign/zero/parity follow saturated z, carry/overflow stay raw).
// Revision : 1.0  initial release
// ============================================================================
module alu_sub_seq #(
  parameter int W     = 16,
  parameter int DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_sub_seq_if.slave  bus
);

  localparam int N  = W / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_w, out_valid_w;

  logic [W-1:0]     x_q, y_q;        // operands, shifted right one digit per BUSY cycle
  logic             xmsb_q, ymsb_q;  // captured operand MSBs for the overflow term
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             zacc_q;          // all slices so far were zero
  logic             pacc_q;          // xor of all result bits so far

  logic [W-1:0]     z_q;
  logic             sign_q, zero_q, parity_q, carry_q, overflow_q;

  logic [DIGIT-1:0] xs, ys, slice;
  logic [DIGIT:0]   diff;
  logic             bout, last;
  logic [W-1:0]     x_shift, y_shift, raw_z;
  logic             zero_raw, par_raw, ov;
  logic [W-1:0]     z_fin;
  logic             zero_fin, parity_fin;

  // ---------------------------------------------------------------------------
  // One digit of subtraction. Widening by one bit makes the MSB of the
  // difference the borrow out of the slice.
  // ---------------------------------------------------------------------------
  assign xs    = x_q[DIGIT-1:0];
  assign ys    = y_q[DIGIT-1:0];
  assign diff  = {1'b0, xs} - {1'b0, ys} - {{DIGIT{1'b0}}, borrow_q};
  assign slice = diff[DIGIT-1:0];
  assign bout  = diff[DIGIT];
  assign last  = (cnt_q == CW'(N - 1));

  generate
    if (N > 1) begin : g_multi
      logic [W-1:0] res_q;  // result digits enter at the top and shift down

      assign x_shift = {{DIGIT{1'b0}}, x_q[W-1:DIGIT]};
      assign y_shift = {{DIGIT{1'b0}}, y_q[W-1:DIGIT]};
      // On the final slice this is the complete raw difference.
      assign raw_z   = {slice, res_q[W-1:DIGIT]};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else if (state_q == S_BUSY) begin
          res_q <= raw_z;
        end
      end
    end else begin : g_single
      assign x_shift = '0;
      assign y_shift = '0;
      assign raw_z   = slice;
    end
  endgenerate

  assign zero_raw = zacc_q & (slice == '0);
  assign par_raw  = ~(pacc_q ^ (^slice));
  assign ov       = (xmsb_q & ~ymsb_q & ~slice[DIGIT-1]) |
                    (~xmsb_q & ymsb_q & slice[DIGIT-1]);

`ifdef ALU_SUB_SAT_EN
  // Clamp toward the operand's sign on overflow; flags describe the clamped z.
  always_comb begin
    z_fin      = raw_z;
    zero_fin   = zero_raw;
    parity_fin = par_raw;
    if (ov) begin
      z_fin      = xmsb_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      zero_fin   = 1'b0;
      parity_fin = ~(^z_fin);
    end
  end
`else
  assign z_fin      = raw_z;
  assign zero_fin   = zero_raw;
  assign parity_fin = par_raw;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_w = 1'b1;
        if (bus.in_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_w = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. Outputs only change at the final BUSY edge so they stay stable
  // through IDLE and BUSY.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      xmsb_q     <= 1'b0;
      ymsb_q     <= 1'b0;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      zacc_q     <= 1'b0;
      pacc_q     <= 1'b0;
      z_q        <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      parity_q   <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_q      <= bus.x;
            y_q      <= bus.y;
            xmsb_q   <= bus.x[W-1];
            ymsb_q   <= bus.y[W-1];
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            zacc_q   <= 1'b1;
            pacc_q   <= 1'b0;
          end
        end
        S_BUSY: begin
          x_q      <= x_shift;
          y_q      <= y_shift;
          borrow_q <= bout;
          zacc_q   <= zero_raw;
          pacc_q   <= pacc_q ^ (^slice);
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            z_q        <= z_fin;
            sign_q     <= z_fin[W-1];
            zero_q     <= zero_fin;
            parity_q   <= parity_fin;
            carry_q    <= bout;
            overflow_q <= ov;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.z         = z_q;
  assign bus.sign      = sign_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sub_seq
// Purpose  : Directed self-checking bench for alu_sub_seq. Main instance uses
//            DIGIT=4; two side instances use DIGIT=1 and DIGIT=16.
//            Honours ALU_SUB_SAT_EN for the overflow vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_sub_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   seen;

  always #5 clk = ~clk;

  alu_sub_seq_if #(.W(16)) bus   ();
  alu_sub_seq_if #(.W(16)) bus1  ();
  alu_sub_seq_if #(.W(16)) bus16 ();

  alu_sub_seq #(.W(16), .DIGIT(4))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_sub_seq #(.W(16), .DIGIT(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_sub_seq #(.W(16), .DIGIT(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] ez, input logic es,
                         input logic ezr, input logic ep, input logic ec, input logic eo);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_z"},     32'(bus.z),         32'(ez));
    chk({tag, "_sign"},  32'(bus.sign),      32'(es));
    chk({tag, "_zero"},  32'(bus.zero),      32'(ezr));
    chk({tag, "_par"},   32'(bus.parity),    32'(ep));
    chk({tag, "_carry"}, 32'(bus.carry),     32'(ec));
    chk({tag, "_ovf"},   32'(bus.overflow),  32'(eo));
  endtask

  // Present operands for one cycle, then count cycles until out_valid (bounded).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int l);
    bus.x        = a;
    bus.y        = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    l = 0;
    while (!bus.out_valid && l < 40) begin
      step();
      l++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;   bus.out_ready = 1'b0;   bus.x = '0;   bus.y = '0;
    bus1.in_valid = 1'b0;  bus1.out_ready = 1'b0;  bus1.x = '0;  bus1.y = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.x = '0; bus16.y = '0;
    step();
    step();

    // Reset state
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_z",         32'(bus.z),         32'd0);
    chk("rst_flags", 32'({bus.sign, bus.zero, bus.parity, bus.carry, bus.overflow}), 32'd0);
    rst_n = 1'b1;
    step();

    // 5 - 3
    run_op(16'h0005, 16'h0003, lat);
    chk("lat_5m3", 32'(lat), 32'd4);
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    chk_res("r_5m3", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_result();
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_in_ready",  32'(bus.in_ready),  32'd1);
    chk("idle_z_hold",    32'(bus.z),         32'h0002);

    // 0 - 1 wraps, with backpressure in DONE
    run_op(16'h0000, 16'h0001, lat);
    chk("lat_0m1", 32'(lat), 32'd4);
    chk_res("r_0m1", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.x = 16'h1111;
    bus.y = 16'h0001;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_z",         32'(bus.z),         32'hFFFF);
      chk("bp_flags", 32'({bus.sign, bus.zero, bus.parity, bus.carry, bus.overflow}), 32'b10110);
    end
    bus.in_valid = 1'b0;
    release_result();
    chk("bp_released", 32'(bus.out_valid), 32'd0);

    // 0x8000 - 1: x negative, y positive, signed overflow
    run_op(16'h8000, 16'h0001, lat);
`ifdef ALU_SUB_SAT_EN
    chk_res("r_8000m1", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    chk_res("r_8000m1", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    release_result();

    // 0x7FFF - 0xFFFF: x positive, y negative, overflow plus borrow
    run_op(16'h7FFF, 16'hFFFF, lat);
`ifdef ALU_SUB_SAT_EN
    chk_res("r_7fffmffff", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`else
    chk_res("r_7fffmffff", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    release_result();

    // 0xA5A5 - 0x5A5A = 0x4B4B raw (signed overflow)
    run_op(16'hA5A5, 16'h5A5A, lat);
`ifdef ALU_SUB_SAT_EN
    chk_res("r_a5a5", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    chk_res("r_a5a5", 16'h4B4B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    release_result();

    // x == y
    run_op(16'h1234, 16'h1234, lat);
    chk("lat_eq", 32'(lat), 32'd4);
    chk_res("r_eq", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    release_result();

    // Borrow ripples through three digits
    run_op(16'h1000, 16'h0001, lat);
    chk_res("r_1000m1", 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    release_result();

    // Reset during the 2nd BUSY cycle
    bus.x = 16'hFFFF;
    bus.y = 16'h0001;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_z",         32'(bus.z),         32'd0);
    chk("mid_rst_flags", 32'({bus.sign, bus.zero, bus.parity, bus.carry, bus.overflow}), 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_valid", 32'(seen), 32'd0);
    run_op(16'h0005, 16'h0003, lat);
    chk("lat_after_rst", 32'(lat), 32'd4);
    chk_res("r_after_rst", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_result();

    // DIGIT=1: x == y, 16-cycle latency
    bus1.x = 16'h1234;
    bus1.y = 16'h1234;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("d1_lat",   32'(lat),   32'd16);
    chk("d1_z",     32'(bus1.z), 32'd0);
    chk("d1_flags", 32'({bus1.sign, bus1.zero, bus1.parity, bus1.carry, bus1.overflow}), 32'b01100);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    chk("d1_released", 32'(bus1.out_valid), 32'd0);

    // DIGIT=16: x == y, single-cycle latency
    bus16.x = 16'h1234;
    bus16.y = 16'h1234;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("d16_lat",   32'(lat),    32'd1);
    chk("d16_z",     32'(bus16.z), 32'd0);
    chk("d16_flags", 32'({bus16.sign, bus16.zero, bus16.parity, bus16.carry, bus16.overflow}), 32'b01100);
    bus16.out_ready = 1'b1;
    step();
    bus16.out_ready = 1'b0;

    // DIGIT=16: 0 - 1 wraps
    bus16.x = 16'h0000;
    bus16.y = 16'h0001;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("d16_wrap_lat", 32'(lat),     32'd1);
    chk("d16_wrap_z",   32'(bus16.z), 32'hFFFF);
    chk("d16_wrap_flags", 32'({bus16.sign, bus16.zero, bus16.parity, bus16.carry, bus16.overflow}), 32'b10110);
    bus16.out_ready = 1'b1;
    step();
    bus16.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
